inst_fetch_resp: RTL and testbench
==================================

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Parameters
REQ-001 SHALL provide parameter TIMEOUT, default 255, giving the maximum cycles to wait for mem_ready_i on one beat before abort.

Interface
REQ-002 SHALL provide: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL provide: rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-004 SHALL provide: ce_i  input  1  fetch enable from PC register.
REQ-005 SHALL provide: pc_i  input  32  fetch byte address from PC register; bits [1:0] ignored.
REQ-006 SHALL provide: inval_i  input  1  invalidate buffered instruction (fence.i).
REQ-007 SHALL provide: inst_o  output  32  fetched instruction to IF/ID.
REQ-008 SHALL provide: inst_valid_o  output  1  inst_o corresponds to current pc_i.
REQ-009 SHALL provide: stallreq_o  output  1  pipeline stall request to ctrl.
REQ-010 SHALL provide: err_o  output  1  one-cycle fetch-timeout pulse.
REQ-011 SHALL provide: mem_addr_o  output  32  byte address to 8-bit instruction memory.
REQ-012 SHALL provide: mem_rd_o  output  1  memory read request.
REQ-013 SHALL provide: mem_data_i  input  8  read byte.
REQ-014 SHALL provide: mem_ready_i  input  1  mem_data_i valid for current mem_addr_o.

Function
REQ-015 SHALL hold a one-word buffer: data[31:0], tag[29:0], valid bit; hit = valid & (tag == pc_i[31:2]).
REQ-016 SHALL implement states IDLE and FETCH with a 2-bit beat counter and a TIMEOUT-wide wait counter.
REQ-017 IDLE, ce_i=1, hit: inst_o=data, inst_valid_o=1, stallreq_o=0, stay IDLE.
REQ-018 IDLE, ce_i=1, miss: latch addr_q=pc_i[31:2], beat=0, wait=0, next state FETCH; stallreq_o=1 combinationally that cycle.
REQ-019 IDLE, ce_i=0: inst_o=0, inst_valid_o=0, stallreq_o=0, mem_rd_o=0, no fetch started.
REQ-020 FETCH: mem_rd_o=1, mem_addr_o={addr_q,beat}; stallreq_o=ce_i; inst_valid_o=0; inst_o=0.
REQ-021 FETCH, mem_ready_i=1: store mem_data_i into staging lane beat (little-endian, beat0->[7:0], beat3->[31:24]), beat+1, wait=0.
REQ-022 Beat 3 accepted: data<=staged word with mem_data_i in [31:24], tag<=addr_q, valid<=1 unless inval_i high that cycle, next state IDLE.
REQ-023 Hit visible the cycle after return to IDLE; with mem_ready_i tied 1, a miss stalls exactly 5 cycles (detect + 4 beats).
REQ-024 pc_i change during FETCH (branch) SHALL NOT abort; fetch completes to addr_q, IDLE then re-evaluates pc_i.
REQ-025 ce_i dropping during FETCH SHALL NOT abort; fetch completes and buffer fills.
REQ-026 inval_i SHALL clear valid next edge in any state; inval_i in IDLE with ce_i=1 forces miss on the following cycle.
REQ-027 FETCH, mem_ready_i=0: wait+1; on wait reaching TIMEOUT: err_o=1 for one cycle, valid<=0, beat<=0, next IDLE (retry when ce_i still 1).
REQ-028 mem_addr_o SHALL be 0 and mem_rd_o 0 whenever state is IDLE.
REQ-029 err_o SHALL be 0 except the single timeout cycle.

Reset
REQ-030 rst=0 SHALL asynchronously force: state IDLE, beat 0, wait 0, valid 0, tag 0, data 0, staging 0.
REQ-031 During and directly after reset all outputs SHALL be 0 (inst_o, inst_valid_o, stallreq_o, err_o, mem_addr_o, mem_rd_o).
REQ-032 rst asserted mid-FETCH SHALL discard partial word; after release first ce_i=1 cycle is a miss.

Verification
REQ-033 Miss: mem bytes 0x13,0x05,0x10,0x00 at 0x0-0x3, ready=1, pc_i=0, ce_i=1 -> stallreq_o high 5 cycles, mem_addr_o 0,1,2,3, then inst_o=0x00100513, inst_valid_o=1.
REQ-034 Hit: pc_i held 0x0 after REQ-033 -> no mem_rd_o, inst_valid_o=1 every cycle; pc_i=0x4 -> new 5-cycle miss, mem_addr_o 4..7.
REQ-035 Wait states: ready low 2 cycles per beat -> stall 13 cycles, correct word, err_o stays 0.
REQ-036 Timeout: TIMEOUT=8, ready stuck 0 -> err_o pulses once 8 cycles into FETCH, valid=0, fetch restarts at beat 0.
REQ-037 Branch/inval mid-fetch: pc_i 0x0->0x40 during beat 1 -> fetch of 0x0 completes, then fetch of 0x40; inval_i on beat 3 -> valid stays 0, pc 0x0 re-fetched.
REQ-038 Reset: rst=0 during beat 2 -> all outputs 0 immediately; after release pc_i=0 -> full 5-cycle miss.

Source files
------------

// File: rtl/inst_fetch_resp_if.sv
// inst_fetch_resp_if -- fetch-side and memory-side signals of inst_fetch_resp.
//   ce_i/pc_i/inval_i       : fetch request from the PC register
//   inst_o/inst_valid_o     : instruction toward IF/ID
//   stallreq_o/err_o        : stall request and fetch-timeout pulse
//   mem_addr_o/mem_rd_o     : byte read request to 8-bit instruction memory
//   mem_data_i/mem_ready_i  : returned byte and its valid strobe
// slave = the fetch unit, master = PC/memory environment.
interface inst_fetch_resp_if;
  logic        ce_i;
  logic [31:0] pc_i;
  logic        inval_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic        err_o;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_data_i;
  logic        mem_ready_i;

  modport slave (
    input  ce_i, pc_i, inval_i, mem_data_i, mem_ready_i,
    output inst_o, inst_valid_o, stallreq_o, err_o, mem_addr_o, mem_rd_o
  );
  modport master (
    output ce_i, pc_i, inval_i, mem_data_i, mem_ready_i,
    input  inst_o, inst_valid_o, stallreq_o, err_o, mem_addr_o, mem_rd_o
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp -- one-word instruction buffer filled from an 8-bit memory.
// A hit on the buffered word is returned combinationally; a miss stalls the
// pipeline while four byte beats are read (little-endian) and assembled.
// A beat that waits TIMEOUT cycles for mem_ready_i aborts with a one-cycle
// err_o pulse; the fetch is retried from beat 0 if ce_i is still high.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : inst_fetch_resp_if.slave (fetch request, instruction, memory)
module inst_fetch_resp #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_resp_if.slave   bus
);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        r_state, w_nxt;
  logic [1:0]    r_beat;
  logic [WW-1:0] r_wait;
  logic          r_valid;
  logic [29:0]   r_tag, r_addr;
  logic [31:0]   r_data;
  logic [23:0]   r_stage;

  logic        w_hit, w_start, w_last, w_timeout;
  logic [31:0] w_inst, w_mem_addr;
  logic        w_inst_valid, w_stall, w_err, w_mem_rd;
  logic        w_unused_pc;

  // Byte offset of the PC is irrelevant for word fetches.
  assign w_unused_pc = ^bus.pc_i[1:0];

  assign w_hit     = r_valid & (r_tag == bus.pc_i[31:2]);
  assign w_start   = (r_state == IDLE) & bus.ce_i & ~w_hit;
  assign w_last    = (r_state == FETCH) & bus.mem_ready_i & (r_beat == 2'd3);
  // Abort when this idle beat would bring the wait count to TIMEOUT.
  assign w_timeout = (r_state == FETCH) & ~bus.mem_ready_i & (r_wait == WLAST);

  // Outputs are held at zero while reset is asserted, even with ce_i high.
  always_comb begin
    w_nxt        = r_state;
    w_inst       = '0;
    w_inst_valid = 1'b0;
    w_stall      = 1'b0;
    w_err        = 1'b0;
    w_mem_addr   = '0;
    w_mem_rd     = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (bus.ce_i) begin
            if (w_hit) begin
              w_inst       = r_data;
              w_inst_valid = 1'b1;
            end else begin
              w_stall = 1'b1;
              w_nxt   = FETCH;
            end
          end
        end
        FETCH: begin
          // Branches and ce_i drops do not abort; the fetch runs to addr_q.
          w_mem_rd   = 1'b1;
          w_mem_addr = {r_addr, r_beat};
          w_stall    = bus.ce_i;
          if (w_last) begin
            w_nxt = IDLE;
          end else if (w_timeout) begin
            w_err = 1'b1;
            w_nxt = IDLE;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  assign bus.inst_o       = w_inst;
  assign bus.inst_valid_o = w_inst_valid;
  assign bus.stallreq_o   = w_stall;
  assign bus.err_o        = w_err;
  assign bus.mem_addr_o   = w_mem_addr;
  assign bus.mem_rd_o     = w_mem_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_wait  <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_start) begin
        r_addr <= bus.pc_i[31:2];
        r_beat <= '0;
        r_wait <= '0;
      end
      if (r_state == FETCH) begin
        if (bus.mem_ready_i) begin
          case (r_beat)
            2'd0: r_stage[7:0]   <= bus.mem_data_i;
            2'd1: r_stage[15:8]  <= bus.mem_data_i;
            2'd2: r_stage[23:16] <= bus.mem_data_i;
            default: begin
              r_data <= {bus.mem_data_i, r_stage};
              r_tag  <= r_addr;
            end
          endcase
          r_beat <= r_beat + 2'd1;
          r_wait <= '0;
        end else if (w_timeout) begin
          r_beat <= '0;
          r_wait <= '0;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end
      // Invalidate wins over a completing fill in the same cycle.
      if (bus.inval_i)     r_valid <= 1'b0;
      else if (w_last)     r_valid <= 1'b1;
      else if (w_timeout)  r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_inst_fetch_resp.sv
module tb_inst_fetch_resp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_resp_if bus();
  inst_fetch_resp #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [7:0] mem [0:255];
  assign bus.mem_data_i = bus.mem_ready_i ? mem[bus.mem_addr_o[7:0]] : 8'hA5;

  int n_chk = 0, n_fail = 0;
  int mode = 0;              // 0 ready tied 1, 1 two waits per beat, 2 random, 3 stuck 0
  bit sb_on = 0, expect_err = 0;
  logic [31:0] sbq [$];
  logic [31:0] aq [$];
  int g_stall = 0, g_err = 0, n_seen = 0;
  logic [1:0] beat_exp = 2'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {mem[8'(b + 8'd3)], mem[8'(b + 8'd2)], mem[8'(b + 8'd1)], mem[b]};
  endfunction

  task automatic chk_zero(input string p);
    chk({p, "_inst"},  bus.inst_o, 32'h0);
    chk({p, "_ival"},  {31'h0, bus.inst_valid_o}, 32'h0);
    chk({p, "_stall"}, {31'h0, bus.stallreq_o}, 32'h0);
    chk({p, "_err"},   {31'h0, bus.err_o}, 32'h0);
    chk({p, "_addr"},  bus.mem_addr_o, 32'h0);
    chk({p, "_rd"},    {31'h0, bus.mem_rd_o}, 32'h0);
  endtask

  task automatic clr();
    aq.delete();
    g_stall = 0;
    g_err = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after inst_valid_o seen or budget spent.
  task automatic wait_valid(input int max, output bit got, output logic [31:0] word);
    int i;
    got = 0; word = '0; i = 0;
    while (!got && i < max) begin
      @(negedge clk);
      if (bus.inst_valid_o) begin got = 1; word = bus.inst_o; end
      i++;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_addrs(input string nm, input logic [31:0] b0, input logic [31:0] b1, input int n);
    chk({nm, "_nbeats"}, aq.size(), n);
    for (int i = 0; i < n && i < aq.size(); i++)
      chk({nm, "_beat_addr"}, aq[i], ((i < 4) ? b0 : b1) + (i % 4));
  endtask

  // Memory ready generator, evaluated mid-cycle once the state has settled.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ready_i = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (mode == 0) bus.mem_ready_i = 1'b1;
      else if (!bus.mem_rd_o || mode == 3) begin bus.mem_ready_i = 1'b0; wcnt = 0; end
      else begin
        if (mode == 1) bus.mem_ready_i = (wcnt == 2);
        else bus.mem_ready_i = (wcnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        wcnt = bus.mem_ready_i ? 0 : wcnt + 1;
      end
    end
  end

  // Logger and scoreboard monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.mem_rd_o && bus.mem_ready_i) aq.push_back(bus.mem_addr_o);
        if (bus.stallreq_o) g_stall++;
        if (bus.err_o) g_err++;
        if (!expect_err) chk("err_quiet", {31'h0, bus.err_o}, 32'h0);
        if (sb_on) begin
          if (bus.inst_valid_o) begin
            if (sbq.size() == 0) chk("sb_unexpected_valid", 32'h1, 32'h0);
            else begin e = sbq.pop_front(); chk("sb_word", bus.inst_o, e); end
            n_seen++;
          end
          if (!bus.ce_i) chk("ce_low_ival", {31'h0, bus.inst_valid_o}, 32'h0);
          if (bus.mem_rd_o) begin
            chk("fetch_addr_word", {2'b0, bus.mem_addr_o[31:2]}, {2'b0, bus.pc_i[31:2]});
            if (bus.mem_ready_i) begin
              chk("beat_order", {30'h0, bus.mem_addr_o[1:0]}, {30'h0, beat_exp});
              beat_exp = beat_exp + 2'd1;
            end
          end else chk("idle_addr", bus.mem_addr_o, 32'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [31:0] w, a;
    int nerr, erri, start;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    bus.ce_i = 1'b0; bus.pc_i = '0; bus.inval_i = 1'b0;

    // Reset
    #3 chk_zero("in_reset");
    repeat (2) @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) chk_zero("after_reset");
    @(posedge clk); #1;

    // Cold miss at 0x0
    clr(); bus.pc_i = 32'h0; bus.ce_i = 1'b1;
    wait_valid(40, got, w);
    chk("miss0_done", {31'h0, got}, 32'h1);
    chk("miss0_word", w, 32'h00100513);
    chk("miss0_stall", g_stall, 5);
    chk_addrs("miss0", 32'h0, 32'h0, 4);

    // Hits while pc held
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hit_ival", {31'h0, bus.inst_valid_o}, 32'h1);
      chk("hit_rd", {31'h0, bus.mem_rd_o}, 32'h0);
      chk("hit_addr", bus.mem_addr_o, 32'h0);
    end
    @(posedge clk); #1;

    // Next word miss
    clr(); bus.pc_i = 32'h4;
    wait_valid(40, got, w);
    chk("miss4_word", w, exp_word(32'h4));
    chk("miss4_stall", g_stall, 5);
    chk_addrs("miss4", 32'h4, 32'h4, 4);

    // Two wait states per beat
    mode = 1; @(posedge clk); #1;
    clr(); bus.pc_i = 32'h8;
    wait_valid(60, got, w);
    chk("ws_word", w, exp_word(32'h8));
    chk("ws_stall", g_stall, 13);
    chk("ws_err", g_err, 0);

    // Timeout with ready stuck low
    mode = 3; expect_err = 1; nerr = 0; erri = 0;
    clr(); bus.pc_i = 32'hC;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.err_o) begin nerr++; erri = i; end
      if (i == 9)  chk("to_ival", {31'h0, bus.inst_valid_o}, 32'h0);
      if (i == 10) begin
        chk("to_retry_stall", {31'h0, bus.stallreq_o}, 32'h1);
        chk("to_retry_idle", {31'h0, bus.mem_rd_o}, 32'h0);
      end
      if (i == 11) chk("to_restart_addr", bus.mem_addr_o, 32'hC);
    end
    chk("to_err_count", nerr, 1);
    chk("to_err_cycle", erri, 9);
    @(posedge clk); #1 mode = 0;
    @(posedge clk); #1 expect_err = 0;
    wait_valid(60, got, w);
    chk("to_recover_word", w, exp_word(32'hC));

    // Branch during beat 1
    clr(); bus.pc_i = 32'h0;
    repeat (2) @(posedge clk); #1 bus.pc_i = 32'h40;
    wait_valid(60, got, w);
    chk("br_word", w, exp_word(32'h40));
    chk("br_stall", g_stall, 10);
    chk_addrs("br", 32'h0, 32'h40, 8);

    // Invalidate on beat 3
    clr(); bus.pc_i = 32'h0;
    repeat (4) @(posedge clk); #1 bus.inval_i = 1'b1;
    @(posedge clk); #1 bus.inval_i = 1'b0;
    wait_valid(60, got, w);
    chk("inv_word", w, 32'h00100513);
    chk("inv_stall", g_stall, 10);
    chk_addrs("inv", 32'h0, 32'h0, 8);

    // Reset during beat 2
    clr(); bus.pc_i = 32'h10;
    repeat (3) @(posedge clk); #2 rst = 1'b0;
    #1 chk_zero("mid_reset");
    @(posedge clk); #1 bus.ce_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) chk_zero("mid_reset_release");
    @(posedge clk); #1;
    clr(); bus.pc_i = 32'h0; bus.ce_i = 1'b1;
    wait_valid(40, got, w);
    chk("rst_miss_word", w, 32'h00100513);
    chk("rst_miss_stall", g_stall, 5);

    // Random traffic against the scoreboard
    bus.ce_i = 1'b0; mode = 2; beat_exp = 2'd0;
    @(posedge clk); #1 sb_on = 1;
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      bus.ce_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      a = 32'($urandom_range(0, 7)) * 4;
      sbq.push_back(exp_word(a));
      bus.pc_i = a; bus.ce_i = 1'b1;
      start = n_seen;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk); #1;
        if (n_seen != start) break;
        bus.inval_i = ($urandom_range(0, 15) == 0);
      end
      bus.inval_i = 1'b0;
      if (n_seen == start) begin
        chk("rand_fetch_timeout", 32'h0, 32'h1);
        break;
      end
    end
    bus.ce_i = 1'b0;
    @(posedge clk); #1;
    chk("sb_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
